// File: rtl/ama_riscv_uart_tx_if.sv
// -----------------------------------------------------------------------------
// ama_riscv_uart_tx_if
// Store handshake between the core's MMIO UART store path and the UART
// transmitter.
//   store_to_uart       core -> uart  store to the UART data register (valid)
//   mmio_uart_data_in   core -> uart  byte to transmit
//   mmio_data_in_ready  uart -> core  transmitter can accept a byte (ready)
// Modports: master = core side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface ama_riscv_uart_tx_if;
  logic       store_to_uart;
  logic [7:0] mmio_uart_data_in;
  logic       mmio_data_in_ready;

  modport master (
    output store_to_uart,
    output mmio_uart_data_in,
    input  mmio_data_in_ready
  );

  modport slave (
    input  store_to_uart,
    input  mmio_uart_data_in,
    output mmio_data_in_ready
  );
endinterface

// File: rtl/ama_riscv_uart_tx.sv
// -----------------------------------------------------------------------------
// ama_riscv_uart_tx
// MMIO UART transmitter. Accepts one byte per core store, buffers it and
// shifts it out 8N1, LSB first, on serial_tx.
//
// Ports:
//   clk         core clock, rising edge
//   rst         asynchronous, active-low reset
//   bus         store handshake (slave modport): store_to_uart,
//               mmio_uart_data_in, mmio_data_in_ready
//   serial_tx   UART line, idle high (registered)
//   tx_busy     frame in progress or buffer non-empty
//   tx_overrun  sticky: a store arrived while ready was 0; cleared by reset
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit, 2..65535
//   FIFO_DEPTH    buffer depth (power of 2, >=2) when UART_TX_FIFO_EN is set
//
// Build option:
//   UART_TX_FIFO_EN  defined   -> FIFO_DEPTH-entry circular FIFO buffer
//                    undefined -> single holding register
// -----------------------------------------------------------------------------
module ama_riscv_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  ama_riscv_uart_tx_if.slave        bus,
  output logic                      serial_tx,
  output logic                      tx_busy,
  output logic                      tx_overrun
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               overrun_q, overrun_d;

  logic               buf_full;
  logic               buf_empty;
  logic [7:0]         buf_head;
  logic               push;
  logic               pop;
  logic               baud_wrap;

  // Ready comes from registered occupancy only, so the core never sees a
  // combinational path from its own store strobe back to ready.
  assign bus.mmio_data_in_ready = ~buf_full;
  assign push                   = bus.store_to_uart & ~buf_full;
  assign baud_wrap              = (baud_cnt_q == CNT_LAST);

`ifdef UART_TX_FIFO_EN
  // ---------------------------------------------------------------------------
  // Circular FIFO. Pointers wrap naturally because FIFO_DEPTH is a power of 2;
  // the count carries one extra bit to tell full from empty.
  // ---------------------------------------------------------------------------
  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign buf_full  = (count_q == DEPTH_C);
  assign buf_empty = (count_q == '0);
  assign buf_head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.mmio_uart_data_in;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single holding register. Push only happens while empty and pop only while
  // full, so they never coincide.
  // ---------------------------------------------------------------------------
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  // FIFO_DEPTH only sizes the FIFO build; tie it off here.
  logic unused_fifo_depth;
  assign unused_fifo_depth = ^FIFO_DEPTH;

  assign buf_full  = full_q;
  assign buf_empty = ~full_q;
  assign buf_head  = hold_q;

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (push) begin
      full_d = 1'b1;
      hold_d = bus.mmio_uart_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM: next state, counters, shifter and next line level.
  // serial_tx is the registered tx_q, so each branch sets the level the line
  // takes right after the edge that enters the next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_d = buf_head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (baud_wrap) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          tx_d       = shift_q[0];
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_wrap) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Next bit is shift_q[1]; it becomes shift_d[0] after the shift.
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (baud_wrap) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_d = buf_head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // Dropped stores latch the overrun flag until reset.
  assign overrun_d = overrun_q | (bus.store_to_uart & buf_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overrun_q  <= overrun_d;
    end
  end

  assign serial_tx  = tx_q;
  assign tx_busy    = (state_q != IDLE) | ~buf_empty;
  assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_ama_riscv_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_ama_riscv_uart_tx
// Directed bench for ama_riscv_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after a rising edge; the line is sampled on
// falling edges, one comparison per cycle of every checked frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ama_riscv_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic serial_tx;
  logic tx_busy;
  logic tx_overrun;

  int total = 0;
  int bad   = 0;

  ama_riscv_uart_tx_if u_if ();

  ama_riscv_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (u_if),
    .serial_tx  (serial_tx),
    .tx_busy    (tx_busy),
    .tx_overrun (tx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle store pulse; returns 1 time unit after the acceptance edge.
  task automatic do_store(input logic [7:0] b);
    u_if.store_to_uart     = 1'b1;
    u_if.mmio_uart_data_in = b;
    step();
    u_if.store_to_uart     = 1'b0;
    u_if.mmio_uart_data_in = 8'($urandom);
  endtask

  // Checks a whole frame cycle by cycle. With skip==0 the start bit must
  // appear within 'bound' falling edges; with skip>0 the first 'skip' frame
  // cycles have already elapsed and the next falling edge is cycle 'skip'.
  // Returns at the falling edge of the last stop-bit cycle.
  task automatic check_frame(input logic [7:0] b, input int bound, input int skip, input string tag);
    logic [9:0] frame;
    int         first;
    int         waited;
    logic       found;
    frame = {1'b1, b, 1'b0};
    first = skip;
    if (skip == 0) begin
      found  = 1'b0;
      waited = 0;
      while (!found && waited < bound) begin
        @(negedge clk);
        waited++;
        if (serial_tx === 1'b0) found = 1'b1;
      end
      chk({tag, "_start"}, {7'd0, found}, 8'd1);
      if (!found) return;
      first = 1;
    end
    for (int i = first; i < 10 * CPB; i++) begin
      @(negedge clk);
      chk({tag, "_bit"}, {7'd0, serial_tx}, {7'd0, frame[i / CPB]});
    end
    $display("frame %s byte=0x%02h checked", tag, b);
  endtask

  logic seen_low;

  initial begin
    rst                    = 1'b0;
    u_if.store_to_uart     = 1'b0;
    u_if.mmio_uart_data_in = 8'h00;
    repeat (3) step();

    // ---- reset values ----
    chk("rst_tx",      {7'd0, serial_tx},               8'd1);
    chk("rst_ready",   {7'd0, u_if.mmio_data_in_ready}, 8'd1);
    chk("rst_busy",    {7'd0, tx_busy},                 8'd0);
    chk("rst_overrun", {7'd0, tx_overrun},              8'd0);
    rst = 1'b1;
    step();
    step();

    // ---- single frame 0xA5, exact latency and length ----
    do_store(8'hA5);
    chk("a5_ready_after_store", {7'd0, u_if.mmio_data_in_ready}, 8'd0);
    chk("a5_busy_after_store",  {7'd0, tx_busy},                 8'd1);
    @(negedge clk);
    chk("a5_tx_high_accept_cycle", {7'd0, serial_tx}, 8'd1);
    check_frame(8'hA5, 1, 0, "a5");
    chk("a5_busy_last_stop_cycle", {7'd0, tx_busy}, 8'd1);
    step();
    chk("a5_tx_idle",  {7'd0, serial_tx},               8'd1);
    chk("a5_busy_end", {7'd0, tx_busy},                 8'd0);
    chk("a5_ready_end",{7'd0, u_if.mmio_data_in_ready}, 8'd1);

    // ---- back-to-back 0x00 then 0xFF, no idle gap ----
    do_store(8'h00);
    step();
    chk("b2b_ready_after_pop", {7'd0, u_if.mmio_data_in_ready}, 8'd1);
    do_store(8'hFF);
    chk("b2b_ready_second", {7'd0, u_if.mmio_data_in_ready}, 8'd0);
    check_frame(8'h00, 0, 1, "b2b_00");
    check_frame(8'hFF, 1, 0, "b2b_ff");
    step();
    chk("b2b_tx_idle",  {7'd0, serial_tx},  8'd1);
    chk("b2b_busy_end", {7'd0, tx_busy},    8'd0);
    chk("b2b_overrun",  {7'd0, tx_overrun}, 8'd0);

`ifndef UART_TX_FIFO_EN
    // ---- single register: third store while full is dropped ----
    do_store(8'h11);
    step();
    do_store(8'h22);
    chk("ovr_ready_full",   {7'd0, u_if.mmio_data_in_ready}, 8'd0);
    chk("ovr_flag_clear",   {7'd0, tx_overrun},              8'd0);
    do_store(8'h33);
    chk("ovr_flag_set",     {7'd0, tx_overrun},              8'd1);
    chk("ovr_ready_still0", {7'd0, u_if.mmio_data_in_ready}, 8'd0);
    check_frame(8'h11, 0, 2, "ovr_11");
    check_frame(8'h22, 1, 0, "ovr_22");
    seen_low = 1'b0;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (serial_tx !== 1'b1) seen_low = 1'b1;
    end
    chk("ovr_no_third_frame", {7'd0, seen_low},   8'd0);
    chk("ovr_flag_sticky",    {7'd0, tx_overrun}, 8'd1);
    chk("ovr_busy_end",       {7'd0, tx_busy},    8'd0);
    step();
`else
    // ---- FIFO: burst of 5 from idle, then a second burst across the wrap ----
    for (int burst = 0; burst < 2; burst++) begin
      for (int k = 0; k < 5; k++) begin
        u_if.store_to_uart     = 1'b1;
        u_if.mmio_uart_data_in = 8'(burst * 5 + k + 1);
        step();
      end
      u_if.store_to_uart = 1'b0;
      chk("fifo_ready_full", {7'd0, u_if.mmio_data_in_ready}, 8'd0);
      chk("fifo_no_overrun", {7'd0, tx_overrun},              8'd0);
      check_frame(8'(burst * 5 + 1), 0, 3, "fifo_first");
      for (int k = 1; k < 5; k++) begin
        check_frame(8'(burst * 5 + k + 1), 1, 0, "fifo_next");
      end
      step();
      chk("fifo_tx_idle",  {7'd0, serial_tx}, 8'd1);
      chk("fifo_busy_end", {7'd0, tx_busy},   8'd0);
    end

    // ---- FIFO: push coincident with pop while holding one entry ----
    do_store(8'hC3);
    step();
    do_store(8'h96);
    check_frame(8'hC3, 0, 1, "coin_c3");
    u_if.store_to_uart     = 1'b1;
    u_if.mmio_uart_data_in = 8'h69;
    step();
    u_if.store_to_uart     = 1'b0;
    chk("coin_ready",   {7'd0, u_if.mmio_data_in_ready}, 8'd1);
    chk("coin_overrun", {7'd0, tx_overrun},              8'd0);
    check_frame(8'h96, 1, 0, "coin_96");
    check_frame(8'h69, 1, 0, "coin_69");
    step();
    chk("coin_busy_end", {7'd0, tx_busy}, 8'd0);
`endif

    // ---- asynchronous reset mid DATA of 0x3C ----
    do_store(8'h3C);
    repeat (12) step();
    chk("rmid_tx_low_before", {7'd0, serial_tx}, 8'd0);
    rst = 1'b0;
    #1;
    chk("rmid_tx",      {7'd0, serial_tx},               8'd1);
    chk("rmid_ready",   {7'd0, u_if.mmio_data_in_ready}, 8'd1);
    chk("rmid_busy",    {7'd0, tx_busy},                 8'd0);
    chk("rmid_overrun", {7'd0, tx_overrun},              8'd0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rmid_tx_after_release", {7'd0, serial_tx}, 8'd1);
    do_store(8'h5A);
    @(negedge clk);
    chk("r5a_tx_high_accept_cycle", {7'd0, serial_tx}, 8'd1);
    check_frame(8'h5A, 1, 0, "r5a");
    step();
    chk("r5a_tx_idle",  {7'd0, serial_tx}, 8'd1);
    chk("r5a_busy_end", {7'd0, tx_busy},   8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ama_riscv_uart_tx.md
Name: ama_riscv_uart_tx

Overview:
- MMIO UART transmitter. It is the receiving end of the core's UART store path (store_to_uart, mmio_uart_data_in, mmio_data_in_ready).
- Accepts one byte per core store, buffers it and serializes it 8N1, LSB first, onto serial_tx.
- Sits beside the core at top level. Its ready output feeds the core's mmio_data_in_ready.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 4, byte buffer depth when UART_TX_FIFO_EN is defined. Power of 2, >=2. Ignored otherwise.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-low reset
- store_to_uart  input  1  core store to UART data register this cycle (valid)
- mmio_uart_data_in  input  8  byte to transmit, sampled when the store is accepted
- mmio_data_in_ready  output  1  buffer can accept a byte (ready)
- serial_tx  output  1  UART line, idle high
- tx_busy  output  1  frame in progress or buffer non-empty
- tx_overrun  output  1  sticky: a store arrived while ready was 0

Behaviour:
- Reset (rst=0, async): serial_tx=1, mmio_data_in_ready=1, tx_busy=0, tx_overrun=0. Buffer is emptied, FSM goes to IDLE, baud and bit counters clear.
- Reset mid-frame aborts the frame immediately. The line returns high asynchronously. The partial byte is not resent.
- Handshake:
  - Byte accepted on a rising edge where store_to_uart=1 and mmio_data_in_ready=1.
  - mmio_data_in_ready = !buffer_full, decoded from registered occupancy only. It has no combinational path from store_to_uart.
  - A store with ready=0 is dropped and sets tx_overrun; it stays set until reset.
- Buffer without the optional feature: a single holding register. Full when loaded, freed when the FSM pops it.
- FSM states: IDLE, START, DATA, STOP. serial_tx is registered.
  - IDLE: line high. If the buffer is non-empty at an edge: pop the head into shift_reg, go to START, drive serial_tx=0.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0 and serial_tx=shift_reg[0].
  - DATA: each bit held CLKS_PER_BIT cycles, shift right. After bit 7 completes, go to STOP with serial_tx=1.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At the end, if the buffer is non-empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps and advances state or bit on wrap.
  - Cleared on every state entry.
- Latency and frame length:
  - Byte accepted at edge N with FSM idle and buffer empty: pop at edge N+1, serial_tx low immediately after N+1.
  - Frame = 10*CLKS_PER_BIT cycles. Line returns idle after edge N+1+10*CLKS_PER_BIT.
- Simultaneous push and pop:
  - The push is accepted only if ready was 1 in that cycle.
  - Occupancy changes by +1, -1 or 0 accordingly.
  - In single-register mode, a push while full and popping is rejected, because ready=0.
- tx_busy = (state != IDLE) || buffer non-empty.
- mmio_uart_data_in is don't-care when store_to_uart=0.

Optional Feature:
- UART_TX_FIFO_EN defined:
  - The buffer is a FIFO_DEPTH-entry circular FIFO with wrap-around pointers of $clog2(FIFO_DEPTH) bits and a count of $clog2(FIFO_DEPTH)+1 bits.
  - Full at count==FIFO_DEPTH, empty at count==0. Bytes are transmitted in acceptance order.
- Not defined: a single holding register (depth 1). All other behaviour is identical.

Test Plan (CLKS_PER_BIT=4):
- Reset then store 0xA5 at edge 10 -> serial_tx low over cycles 11-14, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high. Line idle after cycle 51; tx_busy high for cycles 10-50.
- Two back-to-back stores, 0x00 then 0xFF -> frames contiguous with no idle cycle between the stop bit and the next start bit, total 80 cycles.
- Without FIFO: store 0x11, then 0x22 while the first frame is in flight and a third store while full -> ready=0 after the second store; the third store is dropped and tx_overrun=1. Only 0x11 and 0x22 appear on the line.
- With UART_TX_FIFO_EN, FIFO_DEPTH=4: 5 consecutive stores 0x01..0x05 starting with the FSM idle -> the first is popped, 4 are buffered, ready drops. 0x01..0x05 are transmitted in order; wrap-around is exercised by a second burst of 5.
- Assert rst mid DATA of 0x3C, hold 2 cycles, release -> serial_tx=1 asynchronously, ready=1, tx_busy=0, tx_overrun=0. The next store of 0x5A transmits correctly.
- Store pulse coincident with the pop edge while the buffer holds 1 entry (FIFO mode) -> count stays 1, no overrun, both bytes are sent.
